alu_arbiter: RTL

Arbitrated front-end for the shared 4-bit ALU (16 opcodes, 8-bit result). It accepts operation requests from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It registers the granted operands and opcode, drives the ALU, and captures the result. It returns the result to the originating requester with its own valid/ready handshake, and traps divide-by-zero before the ALU result is used.

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front-end for a shared 4-bit ALU: accepts one request at a time,
// holds operands for ALU_LAT cycles, traps divide-by-zero and returns the result to its owner.
module alu_arbiter #(
  parameter int unsigned ALU_LAT     = 1,
  parameter logic [7:0]  DIV0_RESULT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       busy
);

  localparam logic [3:0] LAT_LOAD = ALU_LAT[3:0];
  localparam logic [3:0] OP_DIV   = 4'b0011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_last;
  logic       r_id;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_op;
  logic [3:0] r_cnt;
  logic [7:0] r_data;
  logic       r_err;

  logic       w_idle_ok;
  logic       w_gnt_any;
  logic       w_gnt_id;
  logic       w_accept;
  logic       w_last_cycle;
  logic       w_rsp_take;
  logic       w_div0;

  // Ready is gated by rst_n so nothing is accepted while reset is asserted.
  assign w_idle_ok    = (r_state == IDLE) && rst_n;
  assign w_gnt_any    = req0_valid || req1_valid;
  assign w_gnt_id     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready   = w_idle_ok && w_gnt_any && !w_gnt_id;
  assign req1_ready   = w_idle_ok && w_gnt_any && w_gnt_id;
  assign w_accept     = w_idle_ok && w_gnt_any;
  assign w_last_cycle = (r_state == EXEC) && (r_cnt == 4'd1);
  assign w_rsp_take   = (r_state == RESP) && (r_id ? rsp1_ready : rsp0_ready);
  assign w_div0       = (r_op == OP_DIV) && (r_b == 4'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EXEC;
      EXEC:    if (w_last_cycle) w_state_next = RESP;
      RESP:    if (w_rsp_take) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_op    <= 4'd0;
      r_cnt   <= 4'd0;
      r_data  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id  <= w_gnt_id;
        r_a   <= w_gnt_id ? req1_a  : req0_a;
        r_b   <= w_gnt_id ? req1_b  : req0_b;
        r_op  <= w_gnt_id ? req1_op : req0_op;
        r_cnt <= LAT_LOAD;
      end else if ((r_state == EXEC) && !w_last_cycle) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // The ALU result is never used for a zero divisor.
      if (w_last_cycle) begin
        r_data <= w_div0 ? DIV0_RESULT : alu_out;
        r_err  <= w_div0;
      end
      if (w_rsp_take) r_last <= r_id;
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp0_valid = (r_state == RESP) && !r_id;
  assign rsp1_valid = (r_state == RESP) && r_id;
  assign rsp0_data  = r_data;
  assign rsp1_data  = r_data;
  assign rsp0_err   = r_err;
  assign rsp1_err   = r_err;
  assign busy       = (r_state != IDLE);

endmodule
